alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Two-stage issue pipeline in front of an external combinational ALU: 8x32 register file,
// operand forwarding from EX and WB, and a single writeback port with backpressure.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic        in_imm_en,
  input  logic [15:0] in_imm,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_C,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [2:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic        ex_valid_q;
  logic [2:0]  ex_rd_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [2:0]  alu_op_q;
  logic        wb_valid_q;
  logic [2:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [31:0] rf_q [8];

  logic        advance;
  logic        accept;
  logic        rf_we;
  logic [31:0] ex_res;
  logic [31:0] opa_d, opb_d, rt_val;

  assign advance  = !wb_valid_q || wb_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign rf_we    = wb_valid_q && wb_ready && (wb_rd_q != 3'd0);

  // Opcodes 110/111 are undefined for the ALU; force a zero result.
  assign ex_res = (alu_op_q[2] && alu_op_q[1]) ? 32'h0 : alu_C;

  always_comb begin
    opa_d = rf_q[in_rs];
    if (in_rs == 3'd0) begin
      opa_d = 32'h0;
    end else if (ex_valid_q && (ex_rd_q == in_rs)) begin
      opa_d = ex_res;
    end else if (wb_valid_q && (wb_rd_q == in_rs)) begin
      opa_d = wb_data_q;
    end
  end

  always_comb begin
    rt_val = rf_q[in_rt];
    if (in_rt == 3'd0) begin
      rt_val = 32'h0;
    end else if (ex_valid_q && (ex_rd_q == in_rt)) begin
      rt_val = ex_res;
    end else if (wb_valid_q && (wb_rd_q == in_rt)) begin
      rt_val = wb_data_q;
    end
    opb_d = in_imm_en ? {{16{in_imm[15]}}, in_imm} : rt_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 3'd0;
      alu_a_q    <= 32'h0;
      alu_b_q    <= 32'h0;
      alu_op_q   <= 3'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 3'd0;
      wb_data_q  <= 32'h0;
    end else if (advance) begin
      wb_valid_q <= ex_valid_q;
      wb_rd_q    <= ex_rd_q;
      wb_data_q  <= ex_res;
      ex_valid_q <= accept;
      if (accept) begin
        ex_rd_q  <= in_rd;
        alu_a_q  <= opa_d;
        alu_b_q  <= opb_d;
        alu_op_q <= in_op;
      end
    end
  end

  // reg[0] is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 32'h0;
      end
    end else if (rf_we) begin
      rf_q[wb_rd_q] <= wb_data_q;
    end
  end

  assign alu_A    = alu_a_q;
  assign alu_B    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule
